// File: rtl/debounce_multi.sv
// Multi-channel button debouncer: 2-flop sync, shared tick prescaler, per-channel stability filter, clean level + press/release strobes.
// Latency 2 cycles + STABLE_TICKS ticks, registered outputs, no backpressure; hold-to-repeat compiled in with DEBOUNCE_REPEAT_EN.
module debounce_multi #(
  parameter int CHANNELS     = 4,
  parameter int TICK_DIV     = 10000,
  parameter int STABLE_TICKS = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_repeat,
  output logic                tick
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = $clog2(STABLE_TICKS + 1);
  localparam logic [TW-1:0] TD_LAST = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] ST_LAST = FW'(STABLE_TICKS - 1);

  logic [CHANNELS-1:0]         sync1_q, sync1_d;
  logic [CHANNELS-1:0]         sync2_q, sync2_d;
  logic [TW-1:0]               presc_q, presc_d;
  logic                        tick_q, tick_d;
  logic [CHANNELS-1:0][FW-1:0] filt_q, filt_d;
  logic [CHANNELS-1:0]         level_q, level_d;
  logic [CHANNELS-1:0]         press_q, press_d;
  logic [CHANNELS-1:0]         release_q, release_d;

  // tick_q mirrors (presc_q == TICK_DIV-1) but comes straight from a flop.
  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    presc_d = (presc_q == TD_LAST) ? '0 : presc_q + TW'(1);
    tick_d  = (presc_d == TD_LAST);
  end

  always_comb begin
    filt_d    = filt_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        filt_d[i] = '0;
      end else if (tick_q) begin
        if (filt_q[i] == ST_LAST) begin
          level_d[i]   = sync2_q[i];
          filt_d[i]    = '0;
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          filt_d[i] = filt_q[i] + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      filt_q    <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      filt_q    <= filt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign tick        = tick_q;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {REP_IDLE, REP_DELAY, REP_RUN} rep_state_e;

  rep_state_e                  rep_state_q [CHANNELS];
  rep_state_e                  rep_state_d [CHANNELS];
  logic [CHANNELS-1:0][RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [CHANNELS-1:0]         repeat_q, repeat_d;

  // Counting on tick_d lines each repeat strobe up with tick_q; entering DELAY
  // on press_d means the tick visible in the press cycle is never counted.
  always_comb begin
    rep_state_d = rep_state_q;
    rep_cnt_d   = rep_cnt_q;
    repeat_d    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (release_d[i]) begin
        rep_state_d[i] = REP_IDLE;
        rep_cnt_d[i]   = '0;
      end else begin
        case (rep_state_q[i])
          REP_IDLE: begin
            if (press_d[i]) begin
              rep_state_d[i] = REP_DELAY;
              rep_cnt_d[i]   = '0;
            end
          end
          REP_DELAY: begin
            if (tick_d) begin
              if (rep_cnt_q[i] == RD_LAST) begin
                repeat_d[i]    = 1'b1;
                rep_cnt_d[i]   = '0;
                rep_state_d[i] = REP_RUN;
              end else begin
                rep_cnt_d[i] = rep_cnt_q[i] + RW'(1);
              end
            end
          end
          REP_RUN: begin
            if (tick_d) begin
              if (rep_cnt_q[i] == RR_LAST) begin
                repeat_d[i]  = 1'b1;
                rep_cnt_d[i] = '0;
              end else begin
                rep_cnt_d[i] = rep_cnt_q[i] + RW'(1);
              end
            end
          end
          default: begin
            rep_state_d[i] = REP_IDLE;
            rep_cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) rep_state_q[i] <= REP_IDLE;
      rep_cnt_q <= '0;
      repeat_q  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) rep_state_q[i] <= rep_state_d[i];
      rep_cnt_q <= rep_cnt_d;
      repeat_q  <= repeat_d;
    end
  end

  assign btn_repeat = repeat_q;
`else
  assign btn_repeat = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: expected strobes are queued as stimulus is planned, and checked as the DUT emits them.
// Timing reference: cyc counts clock edges since reset release, tick expected when cyc % TD == TD-1.
module tb_debounce_multi;

  localparam int TD = 4;
  localparam int ST = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic       clk;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] btn_level, btn_press, btn_release, btn_repeat;
  logic       tick;

  debounce_multi #(
    .CHANNELS(4), .TICK_DIV(TD), .STABLE_TICKS(ST), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct { int cyc; int ch; int kind; } ev_t;  // kind 0 press, 1 release, 2 repeat
  ev_t sb[$];

  function automatic int ev_key(input int c, input int ch, input int kind);
    return c * 64 + ch * 4 + kind;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input int ch, input int kind);
    ev_t e;
    int  i;
    e.cyc = c; e.ch = ch; e.kind = kind;
    i = 0;
    while (i < sb.size() && ev_key(sb[i].cyc, sb[i].ch, sb[i].kind) <= ev_key(c, ch, kind)) i++;
    sb.insert(i, e);
  endtask

  // n-th tick cycle seen by the filter for an input applied in cycle c (visible after 2 sync flops).
  function automatic int nth_tick(input int c, input int n);
    int cnt = 0;
    int res = -1;
    for (int k = c + 2; k < c + 2 + (n + 1) * TD; k++) begin
      if (res < 0 && (k % TD) == TD - 1) begin
        cnt++;
        if (cnt == n) res = k;
      end
    end
    return res;
  endfunction

  function automatic int flip_cyc(input int c);
    return nth_tick(c, ST) + 1;
  endfunction

  // Queue press (and release, if c_off >= 0) plus any repeats in between for one held button.
  task automatic exp_hold(input int ch, input int c_on, input int c_off);
    int p, r, n;
    p = flip_cyc(c_on);
    r = (c_off >= 0) ? flip_cyc(c_off) : c_on + 1000;
    n = 0;
    push_ev(p, ch, 0);
    if (c_off >= 0) push_ev(r, ch, 1);
`ifdef DEBOUNCE_REPEAT_EN
    for (int t = p + 1; t < r; t++) begin
      if ((t % TD) == TD - 1) begin
        n++;
        if (n == RD || (n > RD && ((n - RD) % RR) == 0)) push_ev(t, ch, 2);
      end
    end
`else
    n = r - p;
`endif
  endtask

  logic mon_s;
  ev_t  mon_e;

  always @(negedge clk) begin
    check("tick", {31'b0, tick}, {31'b0, (!rst && (cyc % TD) == TD - 1)});
    for (int ch = 0; ch < 4; ch++) begin
      for (int k = 0; k < 3; k++) begin
        mon_s = (k == 0) ? btn_press[ch] : (k == 1) ? btn_release[ch] : btn_repeat[ch];
        if (mon_s) begin
          if (sb.size() == 0) begin
            check("unexpected_strobe", ev_key(cyc, ch, k), 32'hFFFF_FFFF);
          end else begin
            mon_e = sb.pop_front();
            check("strobe", ev_key(cyc, ch, k), ev_key(mon_e.cyc, mon_e.ch, mon_e.kind));
          end
        end
      end
    end
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      check("missed_strobe", ev_key(cyc, -1, 0), ev_key(mon_e.cyc, mon_e.ch, mon_e.kind));
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_to(input int target);
    int g = 0;
    while (cyc < target && g < 5000) begin
      @(posedge clk); #2;
      g++;
    end
    check("wait_to", cyc, target);
  endtask

  initial begin
    int c, p, r, k2;
    rst    = 1'b1;
    btn_in = 4'b0000;
    step(3);
    check("rst_level",   btn_level,   4'b0000);
    check("rst_press",   btn_press,   4'b0000);
    check("rst_release", btn_release, 4'b0000);
    check("rst_repeat",  btn_repeat,  4'b0000);
    check("rst_tick",    tick,        0);
    rst = 1'b0;
    step(5);

    // Clean press/release on ch0
    c = cyc;
    p = flip_cyc(c);
    r = flip_cyc(c + 40);
    exp_hold(0, c, c + 40);
    btn_in = 4'b0001;
    wait_to(p - 1);
    check("s1_level_before", btn_level, 4'b0000);
    wait_to(p);
    check("s1_level_rise", btn_level, 4'b0001);
    wait_to(c + 40);
    btn_in = 4'b0000;
    wait_to(r - 1);
    check("s1_level_held", btn_level, 4'b0001);
    wait_to(r);
    check("s1_level_fall", btn_level, 4'b0000);
    step(4);

    // Bounce on ch1 (5-cycle toggles), then stable high
    c = cyc;
    exp_hold(1, c + 30, c + 70);
    for (int k = 0; k < 6; k++) begin
      btn_in[1] = (k % 2 == 0);
      step(5);
    end
    btn_in[1] = 1'b1;
    check("s2_level_bounce", btn_level, 4'b0000);
    p = flip_cyc(c + 30);
    wait_to(p);
    check("s2_level_rise", btn_level, 4'b0010);
    wait_to(c + 70);
    btn_in[1] = 1'b0;
    r = flip_cyc(c + 70);
    wait_to(r);
    check("s2_level_fall", btn_level, 4'b0000);
    step(4);

    // One-cycle glitch on ch2
    btn_in[2] = 1'b1;
    step(1);
    btn_in[2] = 1'b0;
    step(100);
    check("s3_glitch_level", btn_level, 4'b0000);

    // ch0 and ch3 together; ch3 stays held into the reset scenario
    c = cyc;
    p = flip_cyc(c);
    exp_hold(0, c, c + 24);
    exp_hold(3, c, -1);
    btn_in = 4'b1001;
    wait_to(p - 1);
    check("s4_press_before", btn_press, 4'b0000);
    wait_to(p);
    check("s4_press_both", btn_press, 4'b1001);
    check("s4_level_both", btn_level, 4'b1001);
    step(1);
    check("s4_press_single", btn_press, 4'b0000);
    wait_to(c + 24);
    btn_in[0] = 1'b0;
    r = flip_cyc(c + 24);
    wait_to(r);
    check("s4_level_ch0_off", btn_level, 4'b1000);
    step(4);

    // Reset while ch1 is two ticks into its filter, ch3 held throughout
    c  = cyc;
    k2 = nth_tick(c, 2);
    btn_in[1] = 1'b1;
    wait_to(k2 + 1);
    check("s5_level_pre", btn_level, 4'b1000);
    rst = 1'b1;
    #1;
    check("s5_rst_level",   btn_level,   4'b0000);
    check("s5_rst_press",   btn_press,   4'b0000);
    check("s5_rst_release", btn_release, 4'b0000);
    check("s5_rst_repeat",  btn_repeat,  4'b0000);
    check("s5_rst_tick",    tick,        0);
    sb.delete();
    step(3);
    rst = 1'b0;
    exp_hold(1, 0, 40);
    exp_hold(3, 0, 40);
    p = flip_cyc(0);
    wait_to(p - 1);
    check("s5_level_refilter", btn_level, 4'b0000);
    wait_to(p);
    check("s5_press_after", btn_press, 4'b1010);
    check("s5_level_after", btn_level, 4'b1010);
    wait_to(40);
    btn_in = 4'b0000;
    r = flip_cyc(40);
    wait_to(r);
    check("s5_level_off", btn_level, 4'b0000);
    step(4);

    // ch0 held 30 ticks: repeats (when compiled in) then silence after release
    c = cyc;
    exp_hold(0, c, c + 30 * TD);
    btn_in[0] = 1'b1;
    wait_to(c + 15 * TD);
`ifndef DEBOUNCE_REPEAT_EN
    check("s6_no_repeat_mid", btn_repeat, 4'b0000);
`endif
    check("s6_level_held", btn_level, 4'b0001);
    wait_to(c + 30 * TD);
    btn_in[0] = 1'b0;
    r = flip_cyc(c + 30 * TD);
    wait_to(r);
    check("s6_level_off", btn_level, 4'b0000);
    step(6 * TD);

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
